// File: rtl/id_ex_pipe_reg_pkg.sv
// rtl/id_ex_pipe_reg_pkg.sv - shared control bundle type, opcodes and source-use decode
package id_ex_pipe_reg_pkg;

   typedef struct packed {
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] alu_op;
      logic       branch;
      logic       jalr_sel;
      logic       valid;
   } ctrl_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   function automatic logic f_uses_rs1(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
             (op == OP_SW) || (op == OP_BR) || (op == OP_JALR);
   endfunction

   function automatic logic f_uses_rs2(input logic [6:0] op);
      return (op == OP_R) || (op == OP_SW) || (op == OP_BR);
   endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - ID-side inputs and EX-side outputs of the ID/EX register
interface id_ex_pipe_reg_if
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RIDX_W = 5,
   parameter int CNT_W  = 16
);
   logic [6:0]        id_opcode;
   ctrl_t             id_ctrl;
   logic [DATA_W-1:0] id_pc;
   logic [DATA_W-1:0] id_rd1;
   logic [DATA_W-1:0] id_rd2;
   logic [DATA_W-1:0] id_imm;
   logic [RIDX_W-1:0] id_rs1;
   logic [RIDX_W-1:0] id_rs2;
   logic [RIDX_W-1:0] id_rd;
   logic [2:0]        id_funct3;
   logic [6:0]        id_funct7;
   logic              ex_flush;

   ctrl_t             ex_ctrl;
   logic [DATA_W-1:0] ex_pc;
   logic [DATA_W-1:0] ex_rd1;
   logic [DATA_W-1:0] ex_rd2;
   logic [DATA_W-1:0] ex_imm;
   logic [RIDX_W-1:0] ex_rs1;
   logic [RIDX_W-1:0] ex_rs2;
   logic [RIDX_W-1:0] ex_rd;
   logic [2:0]        ex_funct3;
   logic [6:0]        ex_funct7;
   logic              stall;
   logic [CNT_W-1:0]  bubble_cnt;

   modport master (
      output id_opcode, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
             id_rs1, id_rs2, id_rd, id_funct3, id_funct7, ex_flush,
      input  ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2,
             ex_rd, ex_funct3, ex_funct7, stall, bubble_cnt
   );

   modport slave (
      input  id_opcode, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
             id_rs1, id_rs2, id_rd, id_funct3, id_funct7, ex_flush,
      output ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2,
             ex_rd, ex_funct3, ex_funct7, stall, bubble_cnt
   );
endinterface

// File: rtl/id_ex_pipe_reg_hazard_detect.sv
// rtl/id_ex_pipe_reg_hazard_detect.sv - combinational load-use hazard detection
module hazard_detect
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int RIDX_W = 5
)(
   input  logic [6:0]        id_opcode,
   input  logic [RIDX_W-1:0] id_rs1,
   input  logic [RIDX_W-1:0] id_rs2,
   input  ctrl_t             ex_ctrl,
   input  logic [RIDX_W-1:0] ex_rd,
   output logic              hz
);
   logic w_ex_load;
   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_unused_ctrl;

   // x0 is never a real producer, and an invalid EX slot carries stale fields
   assign w_ex_load = ex_ctrl.valid & ex_ctrl.mem_read & (ex_rd != '0);
   assign w_rs1_hit = f_uses_rs1(id_opcode) & (ex_rd == id_rs1);
   assign w_rs2_hit = f_uses_rs2(id_opcode) & (ex_rd == id_rs2);
   assign hz        = w_ex_load & (w_rs1_hit | w_rs2_hit);

   assign w_unused_ctrl = ^ex_ctrl;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use stall, bubble insertion
// and a saturating bubble counter
module id_ex_pipe_reg
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RIDX_W = 5,
   parameter int CNT_W  = 16
)(
   input logic             clk,
   input logic             reset,
   id_ex_pipe_reg_if.slave bus
);
   ctrl_t             r_ex_ctrl;
   logic [DATA_W-1:0] r_ex_pc;
   logic [DATA_W-1:0] r_ex_rd1;
   logic [DATA_W-1:0] r_ex_rd2;
   logic [DATA_W-1:0] r_ex_imm;
   logic [RIDX_W-1:0] r_ex_rs1;
   logic [RIDX_W-1:0] r_ex_rs2;
   logic [RIDX_W-1:0] r_ex_rd;
   logic [2:0]        r_ex_funct3;
   logic [6:0]        r_ex_funct7;
   logic [CNT_W-1:0]  r_bubble_cnt;

   logic w_hz;
   logic w_bubble;

   hazard_detect #(.RIDX_W(RIDX_W)) u_hazard_detect (
      .id_opcode (bus.id_opcode),
      .id_rs1    (bus.id_rs1),
      .id_rs2    (bus.id_rs2),
      .ex_ctrl   (r_ex_ctrl),
      .ex_rd     (r_ex_rd),
      .hz        (w_hz)
   );

   // a flush already kills the dependent instruction, so it bubbles without stalling
   assign w_bubble  = bus.ex_flush | w_hz;
   assign bus.stall = w_hz & ~bus.ex_flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ex_ctrl   <= '0;
         r_ex_pc     <= '0;
         r_ex_rd1    <= '0;
         r_ex_rd2    <= '0;
         r_ex_imm    <= '0;
         r_ex_rs1    <= '0;
         r_ex_rs2    <= '0;
         r_ex_rd     <= '0;
         r_ex_funct3 <= '0;
         r_ex_funct7 <= '0;
      end else if (w_bubble) begin
         r_ex_ctrl   <= '0;
         r_ex_pc     <= '0;
         r_ex_rd1    <= '0;
         r_ex_rd2    <= '0;
         r_ex_imm    <= '0;
         r_ex_rs1    <= '0;
         r_ex_rs2    <= '0;
         r_ex_rd     <= '0;
         r_ex_funct3 <= '0;
         r_ex_funct7 <= '0;
      end else begin
         r_ex_ctrl   <= bus.id_ctrl;
         r_ex_pc     <= bus.id_pc;
         r_ex_rd1    <= bus.id_rd1;
         r_ex_rd2    <= bus.id_rd2;
         r_ex_imm    <= bus.id_imm;
         r_ex_rs1    <= bus.id_rs1;
         r_ex_rs2    <= bus.id_rs2;
         r_ex_rd     <= bus.id_rd;
         r_ex_funct3 <= bus.id_funct3;
         r_ex_funct7 <= bus.id_funct7;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bubble_cnt <= '0;
      end else if (w_bubble && (r_bubble_cnt != '1)) begin
         r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
   end

   assign bus.ex_ctrl    = r_ex_ctrl;
   assign bus.ex_pc      = r_ex_pc;
   assign bus.ex_rd1     = r_ex_rd1;
   assign bus.ex_rd2     = r_ex_rd2;
   assign bus.ex_imm     = r_ex_imm;
   assign bus.ex_rs1     = r_ex_rs1;
   assign bus.ex_rs2     = r_ex_rs2;
   assign bus.ex_rd      = r_ex_rd;
   assign bus.ex_funct3  = r_ex_funct3;
   assign bus.ex_funct7  = r_ex_funct7;
   assign bus.bubble_cnt = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - table-driven and sequence checks for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
   import id_ex_pipe_reg_pkg::*;

   localparam logic [9:0] C_NOP  = 10'b0000000000;
   localparam logic [9:0] C_LW   = 10'b1111000001;
   localparam logic [9:0] C_LWX  = 10'b1111000000;
   localparam logic [9:0] C_R    = 10'b0010010001;
   localparam logic [9:0] C_I    = 10'b1010000001;
   localparam logic [9:0] C_SW   = 10'b1000100001;
   localparam logic [9:0] C_BR   = 10'b0000001101;
   localparam logic [9:0] C_JAL  = 10'b0010000001;
   localparam logic [9:0] C_JALR = 10'b1010000011;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   id_ex_pipe_reg_if bus ();

   id_ex_pipe_reg dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [6:0] pre_op;
      logic [9:0] pre_ctrl;
      logic [4:0] pre_rd;
      logic [6:0] op;
      logic [9:0] ctrl;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       flush;
      logic       exp_stall;
      logic       exp_bubble;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic [6:0] op, input logic [9:0] ctrl,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      bus.id_opcode = op;
      bus.id_ctrl   = ctrl_t'(ctrl);
      bus.id_rs1    = rs1;
      bus.id_rs2    = rs2;
      bus.id_rd     = rd;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cnt0;
      total = 0;
      bad   = 0;

      vecs[0]  = '{"lw_add_rs1",   OP_LW, C_LW,  5'd5, OP_R,    C_R,    5'd5, 5'd2, 5'd6, 1'b0, 1'b1, 1'b1};
      vecs[1]  = '{"lw_x0",        OP_LW, C_LW,  5'd0, OP_R,    C_R,    5'd0, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{"lw_sw_rs2",    OP_LW, C_LW,  5'd5, OP_SW,   C_SW,   5'd2, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1};
      vecs[3]  = '{"lw_flush",     OP_LW, C_LW,  5'd5, OP_R,    C_R,    5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{"lw_jal",       OP_LW, C_LW,  5'd5, OP_JAL,  C_JAL,  5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{"lw_jalr",      OP_LW, C_LW,  5'd5, OP_JALR, C_JALR, 5'd5, 5'd0, 5'd1, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{"add_add",      OP_R,  C_R,   5'd5, OP_R,    C_R,    5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{"lw_addi_rs2",  OP_LW, C_LW,  5'd5, OP_I,    C_I,    5'd7, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{"lw_beq_rs2",   OP_LW, C_LW,  5'd5, OP_BR,   C_BR,   5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{"invalid_ex",   OP_LW, C_LWX, 5'd5, OP_R,    C_R,    5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{"flush_nodep",  OP_LW, C_LW,  5'd5, OP_I,    C_I,    5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1};

      // reset held with random inputs
      reset = 1'b0;
      repeat (3) begin
         drive_id(7'($urandom), 10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
         bus.id_pc     = $urandom;
         bus.id_rd1    = $urandom;
         bus.id_rd2    = $urandom;
         bus.id_imm    = $urandom;
         bus.id_funct3 = 3'($urandom);
         bus.id_funct7 = 7'($urandom);
         bus.ex_flush  = 1'($urandom);
         tick();
      end
      chk("rst/ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
      chk("rst/ex_pc", bus.ex_pc, 32'd0);
      chk("rst/ex_rd", 32'(bus.ex_rd), 32'd0);
      chk("rst/ex_imm", bus.ex_imm, 32'd0);
      chk("rst/stall", 32'(bus.stall), 32'd0);
      chk("rst/bubble_cnt", 32'(bus.bubble_cnt), 32'd0);

      // add x3,x1,x2 captured one edge after release
      drive_id(OP_R, C_R, 5'd1, 5'd2, 5'd3);
      bus.id_pc     = 32'h0000_0100;
      bus.id_rd1    = 32'h1111_2222;
      bus.id_rd2    = 32'h3333_4444;
      bus.id_imm    = 32'h0;
      bus.id_funct3 = 3'd0;
      bus.id_funct7 = 7'd0;
      bus.ex_flush  = 1'b0;
      reset = 1'b1;
      tick();
      chk("add/ex_rd", 32'(bus.ex_rd), 32'd3);
      chk("add/reg_write", 32'(bus.ex_ctrl.reg_write), 32'd1);
      chk("add/ex_ctrl", 32'(bus.ex_ctrl), 32'(C_R));
      chk("add/ex_pc", bus.ex_pc, 32'h0000_0100);
      chk("add/ex_rd1", bus.ex_rd1, 32'h1111_2222);
      chk("add/ex_rd2", bus.ex_rd2, 32'h3333_4444);
      chk("add/ex_rs2", 32'(bus.ex_rs2), 32'd2);
      chk("add/bubble_cnt", 32'(bus.bubble_cnt), 32'd0);

      for (int i = 0; i < 11; i++) begin
         bus.ex_flush = 1'b0;
         drive_id(7'd0, C_NOP, 5'd0, 5'd0, 5'd0);
         tick();
         drive_id(vecs[i].pre_op, vecs[i].pre_ctrl, 5'd1, 5'd0, vecs[i].pre_rd);
         tick();
         chk($sformatf("%s/pre_rd", vecs[i].name), 32'(bus.ex_rd), 32'(vecs[i].pre_rd));
         drive_id(vecs[i].op, vecs[i].ctrl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
         bus.ex_flush = vecs[i].flush;
         #1;
         chk($sformatf("%s/stall", vecs[i].name), 32'(bus.stall), 32'(vecs[i].exp_stall));
         cnt0 = bus.bubble_cnt;
         tick();
         bus.ex_flush = 1'b0;
         #1;
         chk($sformatf("%s/ex_ctrl1", vecs[i].name), 32'(bus.ex_ctrl),
             vecs[i].exp_bubble ? 32'd0 : 32'(vecs[i].ctrl));
         chk($sformatf("%s/ex_rd1", vecs[i].name), 32'(bus.ex_rd),
             vecs[i].exp_bubble ? 32'd0 : 32'(vecs[i].rd));
         chk($sformatf("%s/cnt_delta", vecs[i].name), 32'(bus.bubble_cnt - cnt0),
             32'(vecs[i].exp_bubble));
         chk($sformatf("%s/stall2", vecs[i].name), 32'(bus.stall), 32'd0);
         tick();
         chk($sformatf("%s/ex_ctrl2", vecs[i].name), 32'(bus.ex_ctrl), 32'(vecs[i].ctrl));
         chk($sformatf("%s/ex_rd2", vecs[i].name), 32'(bus.ex_rd), 32'(vecs[i].rd));
      end

      // reset asserted during a stall clears outputs before the next edge
      drive_id(7'd0, C_NOP, 5'd0, 5'd0, 5'd0);
      tick();
      drive_id(OP_LW, C_LW, 5'd1, 5'd0, 5'd5);
      tick();
      drive_id(OP_R, C_R, 5'd5, 5'd2, 5'd6);
      #1;
      chk("rststall/stall_before", 32'(bus.stall), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rststall/stall", 32'(bus.stall), 32'd0);
      chk("rststall/ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
      chk("rststall/ex_rd", 32'(bus.ex_rd), 32'd0);
      chk("rststall/bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
      tick();
      reset = 1'b1;

      // saturation: 65534 flush bubbles from zero, then 3 more
      drive_id(7'd0, C_NOP, 5'd0, 5'd0, 5'd0);
      bus.ex_flush = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat/fffe", 32'(bus.bubble_cnt), 32'h0000_FFFE);
      repeat (3) tick();
      chk("sat/ffff", 32'(bus.bubble_cnt), 32'h0000_FFFF);
      bus.ex_flush = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
